// File: rtl/poly_note_pkg.sv
// Shared constants and helpers for the polyphonic tone generator.
// Volume table, pan routing codes and mix saturation.
package poly_note_pkg;

   // amplitude per volume index, entry 7 first
   localparam logic [7:0][15:0] VOL_TAB = {
      16'h3000, 16'h2800, 16'h2000, 16'h1800,
      16'h1000, 16'h0800, 16'h0400, 16'h0000
   };

   localparam logic [1:0] PAN_MUTE = 2'b00;
   localparam logic [1:0] PAN_L    = 2'b01;
   localparam logic [1:0] PAN_R    = 2'b10;
   localparam logic [1:0] PAN_LR   = 2'b11;

   // clamp a wide signed sum into a w-bit two's complement range
   function automatic logic signed [31:0] sat_amp(
      input logic signed [31:0] s,
      input int                 w
   );
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

endpackage

// File: rtl/poly_note_gen_channel.sv
// One square-wave tone channel: divider counter, phase and pending note slot.
// New dividers are applied only on a waveform edge, or at once when silent.
module note_channel
   import poly_note_pkg::*;
#(
   parameter int DIV_W = 22,
   parameter int AMP_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DIV_W-1:0]        note_div,
   input  logic                    note_vld,
   output logic                    note_rdy,
   input  logic [2:0]              volume,
   output logic signed [AMP_W-1:0] contrib,
   output logic                    silent
);

   logic [DIV_W-1:0] act;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] pend;
   logic             ph;
   logic             pv;
   logic             accept;
   logic signed [AMP_W-1:0] amp;

   assign note_rdy = ~pv;
   assign accept   = note_vld & ~pv;
   assign silent   = (act <= DIV_W'(1));

   // amplitude lookup and phase sign, forced to zero while silent
   always_comb begin
      amp     = signed'(AMP_W'(VOL_TAB[volume]));
      contrib = '0;
      if (!silent)
         contrib = ph ? -amp : amp;
   end

   // counter, phase and pending slot; accept and apply never coincide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act  <= '0;
         cnt  <= '0;
         pend <= '0;
         ph   <= 1'b0;
         pv   <= 1'b0;
      end else begin
         if (accept) begin
            pend <= note_div;
            pv   <= 1'b1;
         end
         if (silent) begin
            cnt <= '0;
            ph  <= 1'b0;
            if (pv) begin
               act <= pend;
               pv  <= 1'b0;
            end
         end else if (cnt == act) begin
            cnt <= '0;
            ph  <= ~ph;
            if (pv) begin
               act <= pend;
               pv  <= 1'b0;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/poly_note_gen.sv
// Polyphonic square-wave generator: NCH tone channels mixed to stereo.
// Routing, two adder trees, saturation and registered outputs.
module poly_note_gen
   import poly_note_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DIV_W = 22,
   parameter int AMP_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*DIV_W-1:0] note_div,
   input  logic [NCH-1:0]       note_vld,
   output logic [NCH-1:0]       note_rdy,
   input  logic [NCH*3-1:0]     volume,
   input  logic [NCH*2-1:0]     pan,
   output logic [AMP_W-1:0]     audio_left,
   output logic [AMP_W-1:0]     audio_right
);

   localparam int SUM_W = AMP_W + 3;

   logic signed [AMP_W-1:0] contrib [NCH];
   logic [NCH-1:0]          silent;
   logic signed [SUM_W-1:0] sum_l;
   logic signed [SUM_W-1:0] sum_r;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      note_channel #(
         .DIV_W (DIV_W),
         .AMP_W (AMP_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .note_div (note_div[i*DIV_W +: DIV_W]),
         .note_vld (note_vld[i]),
         .note_rdy (note_rdy[i]),
         .volume   (volume[i*3 +: 3]),
         .contrib  (contrib[i]),
         .silent   (silent[i])
      );
   end

   // route each channel by its pan code and sum per side
   always_comb begin
      sum_l = '0;
      sum_r = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!silent[i]) begin
            unique case (pan[i*2 +: 2])
               PAN_L:   sum_l = sum_l + SUM_W'(contrib[i]);
               PAN_R:   sum_r = sum_r + SUM_W'(contrib[i]);
               PAN_LR: begin
                  sum_l = sum_l + SUM_W'(contrib[i]);
                  sum_r = sum_r + SUM_W'(contrib[i]);
               end
               default: ;
            endcase
         end
      end
   end

   // saturate and register the stereo sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         audio_left  <= '0;
         audio_right <= '0;
      end else begin
         audio_left  <= AMP_W'(sat_amp(32'(sum_l), AMP_W));
         audio_right <= AMP_W'(sat_amp(32'(sum_r), AMP_W));
      end
   end

endmodule

// File: tb/tb_poly_note_gen.sv
// Directed self-checking bench for poly_note_gen.
// Table-driven volume/pan sweep plus hand-written handshake sequences.
module tb_poly_note_gen;

   localparam int NCH   = 4;
   localparam int DIV_W = 22;
   localparam int AMP_W = 16;

   logic                 clk;
   logic                 rst;
   logic [NCH*DIV_W-1:0] note_div;
   logic [NCH-1:0]       note_vld;
   logic [NCH-1:0]       note_rdy;
   logic [NCH*3-1:0]     volume;
   logic [NCH*2-1:0]     pan;
   logic [AMP_W-1:0]     audio_left;
   logic [AMP_W-1:0]     audio_right;

   int total;
   int bad;

   typedef struct {
      logic [2:0]  vol;
      logic [1:0]  pn;
      logic [15:0] l;
      logic [15:0] r;
   } vec_t;

   vec_t tab [16];

   poly_note_gen #(
      .NCH   (NCH),
      .DIV_W (DIV_W),
      .AMP_W (AMP_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .note_div    (note_div),
      .note_vld    (note_vld),
      .note_rdy    (note_rdy),
      .volume      (volume),
      .pan         (pan),
      .audio_left  (audio_left),
      .audio_right (audio_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, a, e);
      end
   endtask

   task automatic set_ch(input int i, input logic [DIV_W-1:0] d,
                         input logic [2:0] v, input logic [1:0] p);
      note_div[i*DIV_W +: DIV_W] = d;
      volume[i*3 +: 3]           = v;
      pan[i*2 +: 2]              = p;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      note_div = '0;
      note_vld = '0;
      volume   = '0;
      pan      = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;

      tab[0]  = '{3'd7, 2'b01, 16'h3000, 16'h0000};
      tab[1]  = '{3'd7, 2'b01, 16'h3000, 16'h0000};
      tab[2]  = '{3'd7, 2'b11, 16'h3000, 16'h3000};
      tab[3]  = '{3'd7, 2'b01, 16'hD000, 16'h0000};
      tab[4]  = '{3'd7, 2'b10, 16'h0000, 16'hD000};
      tab[5]  = '{3'd3, 2'b11, 16'hF000, 16'hF000};
      tab[6]  = '{3'd0, 2'b11, 16'h0000, 16'h0000};
      tab[7]  = '{3'd1, 2'b01, 16'h0400, 16'h0000};
      tab[8]  = '{3'd2, 2'b00, 16'h0000, 16'h0000};
      tab[9]  = '{3'd4, 2'b01, 16'h1800, 16'h0000};
      tab[10] = '{3'd7, 2'b01, 16'h3000, 16'h0000};
      tab[11] = '{3'd7, 2'b01, 16'hD000, 16'h0000};
      tab[12] = '{3'd5, 2'b10, 16'h0000, 16'hE000};
      tab[13] = '{3'd6, 2'b01, 16'hD800, 16'h0000};
      tab[14] = '{3'd7, 2'b01, 16'hD000, 16'h0000};
      tab[15] = '{3'd7, 2'b01, 16'h3000, 16'h0000};

      // reset state
      do_reset();
      chk("rst_left", 32'(audio_left), 32'h0);
      chk("rst_right", 32'(audio_right), 32'h0);
      chk("rst_rdy", 32'(note_rdy), 32'hF);

      // ch0 div=3 from silent: first sample 3 cycles after accept
      set_ch(0, 22'd3, 3'd7, 2'b01);
      note_vld = 4'b0001;
      step();
      note_vld = '0;
      chk("t1_rdy_low", 32'(note_rdy), 32'hE);
      step();
      chk("t1_apply_left", 32'(audio_left), 32'h0);
      chk("t1_apply_rdy", 32'(note_rdy), 32'hF);
      step();
      chk("t1_first_left", 32'(audio_left), 32'h3000);
      chk("t1_first_right", 32'(audio_right), 32'h0);

      // volume and pan sweep while ch0 runs
      for (int k = 0; k < 16; k++) begin
         set_ch(0, 22'd3, tab[k].vol, tab[k].pn);
         step();
         chk($sformatf("tab%0d_left", k), 32'(audio_left), 32'(tab[k].l));
         chk($sformatf("tab%0d_right", k), 32'(audio_right), 32'(tab[k].r));
      end

      // pitch change mid half-period waits for the edge
      set_ch(0, 22'd7, 3'd7, 2'b01);
      note_vld = 4'b0001;
      step();
      note_vld = '0;
      chk("t2_acc_rdy", 32'(note_rdy[0]), 32'h0);
      chk("t2_acc_left", 32'(audio_left), 32'h3000);
      step();
      chk("t2_wait_rdy", 32'(note_rdy[0]), 32'h0);
      chk("t2_wait_left", 32'(audio_left), 32'h3000);
      step();
      chk("t2_edge_rdy", 32'(note_rdy[0]), 32'h1);
      chk("t2_edge_left", 32'(audio_left), 32'h3000);
      for (int k = 0; k < 16; k++) begin
         step();
         chk($sformatf("t2_half%0d", k), 32'(audio_left),
             (k < 8) ? 32'hD000 : 32'h3000);
      end
      step();
      chk("t2_next_half", 32'(audio_left), 32'hD000);

      // silent divider values then a real note on ch1
      do_reset();
      set_ch(1, 22'd1, 3'd7, 2'b01);
      note_vld = 4'b0010;
      step();
      note_vld = '0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t3_div1_%0d", k), 32'(audio_left), 32'h0);
      end
      chk("t3_div1_rdy", 32'(note_rdy), 32'hF);
      set_ch(1, 22'd0, 3'd7, 2'b01);
      note_vld = 4'b0010;
      step();
      note_vld = '0;
      step();
      step();
      chk("t3_div0_left", 32'(audio_left), 32'h0);
      set_ch(1, 22'd2, 3'd7, 2'b01);
      note_vld = 4'b0010;
      step();
      note_vld = '0;
      chk("t3_acc_left", 32'(audio_left), 32'h0);
      step();
      chk("t3_apl_left", 32'(audio_left), 32'h0);
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("t3_run%0d", k), 32'(audio_left),
             (k < 3 || k == 6) ? 32'h3000 : 32'hD000);
      end

      // four channels in unison saturate both sides
      do_reset();
      for (int i = 0; i < NCH; i++) set_ch(i, 22'd5, 3'd7, 2'b11);
      note_vld = 4'b1111;
      step();
      note_vld = '0;
      step();
      for (int k = 0; k < 13; k++) begin
         step();
         chk($sformatf("t4_l%0d", k), 32'(audio_left),
             (k < 6 || k == 12) ? 32'h7FFF : 32'h8000);
         chk($sformatf("t4_r%0d", k), 32'(audio_right),
             (k < 6 || k == 12) ? 32'h7FFF : 32'h8000);
      end

      // back-to-back requests held on ch2
      do_reset();
      set_ch(2, 22'd3, 3'd7, 2'b01);
      note_vld = 4'b0100;
      step();
      note_vld = '0;
      step();
      set_ch(2, 22'd5, 3'd7, 2'b01);
      note_vld = 4'b0100;
      step();
      chk("t5_first_acc", 32'(note_rdy[2]), 32'h0);
      set_ch(2, 22'd9, 3'd7, 2'b01);
      n = 0;
      while (note_rdy[2] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("t5_wait_cycles", 32'(n), 32'd3);
      step();
      note_vld = '0;
      chk("t5_second_acc", 32'(note_rdy[2]), 32'h0);
      chk("t5_g_left", 32'(audio_left), 32'hD000);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t5_lo%0d", k), 32'(audio_left), 32'hD000);
      end
      chk("t5_apply2_rdy", 32'(note_rdy[2]), 32'h1);
      for (int k = 0; k < 11; k++) begin
         step();
         chk($sformatf("t5_hi%0d", k), 32'(audio_left),
             (k < 10) ? 32'h3000 : 32'hD000);
      end

      // async reset mid-waveform with requests pending everywhere
      do_reset();
      for (int i = 0; i < NCH; i++) set_ch(i, 22'd3, 3'd7, 2'b11);
      note_vld = 4'b1111;
      step();
      note_vld = '0;
      step();
      step();
      step();
      for (int i = 0; i < NCH; i++) set_ch(i, 22'd7, 3'd7, 2'b11);
      note_vld = 4'b1111;
      step();
      note_vld = '0;
      chk("t6_pending", 32'(note_rdy), 32'h0);
      chk("t6_pre_left", 32'(audio_left), 32'h7FFF);
      rst = 1'b1;
      #1;
      chk("t6_async_left", 32'(audio_left), 32'h0);
      chk("t6_async_right", 32'(audio_right), 32'h0);
      chk("t6_async_rdy", 32'(note_rdy), 32'hF);
      step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("t6_quiet%0d", k),
             32'({audio_left, audio_right}), 32'h0);
      end
      chk("t6_rdy_after", 32'(note_rdy), 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/poly_note_gen.md
# poly_note_gen

Parametrised polyphonic square-wave tone generator for the audio path. Drives NCH independent tone channels, each with its own note divider, 3-bit volume and stereo pan. Channels are summed into saturated signed left/right samples for the I2S/DAC serializer. Note changes use a per-channel valid/ready handshake and are applied only at a waveform edge, so a pitch change never produces a truncated half-period.

## Interface
- NCH, 4: number of tone channels (1..8)
- DIV_W, 22: note divider width
- AMP_W, 16: audio sample width, two's complement
- clk  in  1  system clock (crystal)
- rst  in  1  reset, asynchronous, active-high
- note_div  in  NCH*DIV_W  requested divider per channel; channel i uses bits [i*DIV_W +: DIV_W]
- note_vld  in  NCH  per-channel request strobe
- note_rdy  out  NCH  per-channel ready; high when the channel's pending slot is empty
- volume  in  NCH*3  per-channel volume index, 0..7
- pan  in  NCH*2  per-channel routing: 00 mute, 01 left, 10 right, 11 both
- audio_left  out  AMP_W  mixed left sample, signed, registered
- audio_right  out  AMP_W  mixed right sample, signed, registered

## Operation
- Each channel holds: active divider `act`, counter `cnt` (DIV_W), phase bit `ph`, pending divider `pend`, and pending-valid flag `pv`.
- Silent channel: `act` is 0 or 1. `cnt` and `ph` are held at 0, and the channel contributes 0.
- Running channel: when `cnt == act`, `cnt` goes to 0 and `ph` toggles. Otherwise `cnt` increments. A half-period is `act+1` cycles.
- Handshake: when `note_vld[i] && note_rdy[i]`, the channel captures `pend <= note_div[i]` and sets `pv <= 1`. `note_rdy[i] = ~pv`. A request while `pv=1` is ignored; the requester holds `vld` until `rdy`.
- Apply, running channel: at the cycle where `cnt == act && pv`, the channel loads `act <= pend`, clears `pv`, sets `cnt` to 0 and toggles `ph` as normal.
- Apply, silent channel: the cycle after capture, the channel loads `act <= pend`, clears `pv` and sets `cnt` and `ph` to 0.
- Accept and apply never happen in the same cycle. A value accepted on a toggle cycle waits for the next toggle.
- Amplitude per channel: `a = VOL_TAB[volume]`. VOL_TAB = 0, 0x0400, 0x0800, 0x1000, 0x1800, 0x2000, 0x2800, 0x3000.
- Channel contribution: `+a` when `ph=0`, `-a` when `ph=1`, and 0 when silent.
- Volume and pan are sampled every cycle, with no handshake.
- Mix: sum the contributions routed to each side at width AMP_W+3, signed.
- Saturation: a sum above 2^(AMP_W-1)-1 outputs 0x7FFF. A sum below -2^(AMP_W-1) outputs 0x8000 (values for AMP_W=16).

## Timing
- Reset values: audio_left = audio_right = 0; note_rdy all 1; every `act`, `cnt`, `ph` and `pv` at 0 (all channels silent).
- Latency: audio outputs are registered. The output at cycle t+1 reflects `ph`, volume and pan at cycle t.
- From a silent channel, the first non-zero sample appears 3 cycles after the `vld&&rdy` cycle: capture, then apply, then register.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Pending requests are discarded.
- Divider wrap: `cnt` never exceeds `act`, so there is no overflow path.
- Changing `act` affects only the half-period that begins after the apply cycle.

## Structure
- Package `poly_note_pkg` holds:
  - VOL_TAB constant
  - pan encoding constants (PAN_MUTE, PAN_L, PAN_R, PAN_LR)
  - function `sat_amp` (wide signed sum to AMP_W)
- Sub-module `note_channel`, instantiated NCH times. It contains the counter, phase, pending slot and handshake, and outputs a signed contribution plus a silent flag.
- The top level holds only the routing, the two adder trees, saturation and the output registers.

## Test plan
- NCH=4. Ch0: div=3, vol=7, pan=01; others silent. Required: audio_left alternates 0x3000 ×4 cycles then 0xD000 ×4 cycles; audio_right stays 0.
- Ch0 running div=3. Send div=7 mid half-period. Required: note_rdy[0] low until the next toggle; the current half-period completes at 4 cycles; following half-periods are 8 cycles; no short half-period.
- All 4 channels: div=5, vol=7, pan=11, started together. Required: both outputs alternate 0x7FFF and 0x8000 (saturated ±0xC000).
- Ch1: div=1 or div=0 with vol=7. Required: contribution 0 and `cnt` held. Then send div=2: first sample +0x3000 appears 3 cycles after acceptance.
- Hold note_vld[2] for 2 requests back-to-back on a running channel. Required: the second request is not accepted until note_rdy[2] rises after the first apply.
- Assert rst for 1 cycle mid-waveform with pending requests on all channels. Required: outputs are 0 immediately, note_rdy is 4'b1111, and all channels are silent afterwards.
